// File: rtl/table_entry_fetcher_if.sv
// DRAM lane port and BUFFER_ENTRY output stream of the table entry fetcher.
// master is the fetcher side; slave is the DRAM / downstream buffer side.
interface table_entry_fetcher_if;
  logic [7:0]       dram_en;
  logic             dram_rdwr;
  logic [7:0][63:0] dram_addr;
  logic [7:0]       dram_valid;
  logic             out_valid;
  logic             out_ready;
  logic [128:0]     out_entry;

  modport master (
    output dram_en, dram_rdwr, dram_addr, out_valid, out_entry,
    input  dram_valid, out_ready
  );

  modport slave (
    input  dram_en, dram_rdwr, dram_addr, out_valid, out_entry,
    output dram_valid, out_ready
  );
endinterface

// File: rtl/table_entry_fetcher.sv
// Walks a contiguous TABLE_ENTRY array in DRAM, fetching each entry as two 8-byte
// beats over the 8-lane port, and emits each entry as a BUFFER_ENTRY.
module table_entry_fetcher #(
  parameter int CNT_W       = 16,
  parameter int ENTRY_BYTES = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [63:0]            base_addr,
  input  logic [CNT_W-1:0]       num_entries,
  output logic                   busy,
  output logic                   done,
  inout  wire  [7:0][7:0]        dram_data,
  table_entry_fetcher_if.master  bus
);

  typedef enum logic [1:0] {IDLE, LO, HI, EMIT} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [63:0]       entry_addr_q, entry_addr_d;
  logic [7:0]        lane_en_q, lane_en_d;
  logic [7:0]        lane_done_q, lane_done_d;
  logic [15:0][7:0]  bytes_q, bytes_d;
  logic              done_q, done_d;

  logic [7:0]        lane_fire;
  logic [7:0]        lane_done_next;
  logic [63:0]       beat_addr;

  assign dram_data     = 'z;
  assign bus.dram_rdwr = 1'b0;
  assign bus.dram_en   = lane_en_q;
  assign bus.out_valid = (state_q == EMIT);
  assign bus.out_entry = (state_q == EMIT) ? {1'b1, bytes_q} : '0;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;

  // A lane completes when it is still requesting and sees valid; stray valids are dropped.
  always_comb begin
    lane_fire      = lane_en_q & bus.dram_valid;
    lane_done_next = lane_done_q | lane_fire;
    beat_addr      = entry_addr_q + ((state_q == HI) ? 64'd8 : 64'd0);
  end

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      bus.dram_addr[j] = lane_en_q[j] ? (beat_addr + 64'(j)) : 64'd0;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    count_d      = count_q;
    entry_addr_d = entry_addr_q;
    lane_en_d    = lane_en_q;
    lane_done_d  = lane_done_q;
    bytes_d      = bytes_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_entries == '0) begin
            done_d = 1'b1;
          end else begin
            count_d      = num_entries;
            idx_d        = '0;
            entry_addr_d = base_addr;
            lane_en_d    = '1;
            state_d      = LO;
          end
        end
      end

      LO, HI: begin
        for (int j = 0; j < 8; j++) begin
          if (lane_fire[j]) begin
            bytes_d[(state_q == HI) ? (j + 8) : j] = dram_data[j];
          end
        end
        // The beat finishes on the same edge as its last valid, so the next beat starts immediately.
        if (&lane_done_next) begin
          lane_done_d = '0;
          if (state_q == LO) begin
            lane_en_d = '1;
            state_d   = HI;
          end else begin
            lane_en_d = '0;
            state_d   = EMIT;
          end
        end else begin
          lane_done_d = lane_done_next;
          lane_en_d   = lane_en_q & ~lane_fire;
        end
      end

      EMIT: begin
        if (bus.out_ready) begin
          idx_d = idx_q + CNT_W'(1);
          if (idx_d == count_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            entry_addr_d = entry_addr_q + 64'(ENTRY_BYTES);
            lane_en_d    = '1;
            state_d      = LO;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      count_q      <= '0;
      entry_addr_q <= '0;
      lane_en_q    <= '0;
      lane_done_q  <= '0;
      bytes_q      <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      count_q      <= count_d;
      entry_addr_q <= entry_addr_d;
      lane_en_q    <= lane_en_d;
      lane_done_q  <= lane_done_d;
      bytes_q      <= bytes_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_table_entry_fetcher.sv
// Bench for table_entry_fetcher: a latency-configurable DRAM model plus a memory-image
// reference for each emitted entry, lane address and request protocol.
module tb_table_entry_fetcher;
  localparam int CNT_W = 16;

  logic             clock;
  logic             reset;
  logic             start;
  logic [63:0]      base_addr;
  logic [CNT_W-1:0] num_entries;
  logic             busy;
  logic             done;
  wire  [7:0][7:0]  dram_data;
  logic [7:0][7:0]  mem_drive;

  table_entry_fetcher_if bus();

  table_entry_fetcher #(.CNT_W(CNT_W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .num_entries (num_entries),
    .busy        (busy),
    .done        (done),
    .dram_data   (dram_data),
    .bus         (bus)
  );

  assign dram_data = mem_drive;

  int checks = 0;
  int passes = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory image: byte value derived from its address, identity on the low page.
  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    return a[7:0] ^ a[23:16] ^ a[63:56];
  endfunction

  function automatic logic [128:0] model_entry(input logic [63:0] b, input int i);
    logic [127:0] e;
    for (int k = 0; k < 16; k++) e[8*k +: 8] = mem_byte(b + 64'(16 * i) + 64'(k));
    return {1'b1, e};
  endfunction

  int         age [8];
  int         lat [8];
  int         lat_fix [8];
  bit         lat_rand;
  logic [7:0] spur;

  // Each lane answers after its own latency, counted from the cycle its enable rises.
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      bus.dram_valid[j] = (bus.dram_en[j] && (age[j] >= lat[j])) || spur[j];
      mem_drive[j]      = mem_byte(bus.dram_addr[j]);
    end
  end

  always @(posedge clock) begin
    for (int j = 0; j < 8; j++) begin
      if (reset || !bus.dram_en[j] || bus.dram_valid[j]) begin
        age[j] <= 0;
        lat[j] <= lat_rand ? int'($urandom_range(5, 1)) : lat_fix[j];
      end else begin
        age[j] <= age[j] + 1;
      end
    end
  end

  logic [128:0] got_q [$];
  logic [7:0]   prev_en, prev_fire;
  logic [63:0]  prev_addr [8];
  logic [63:0]  mon_base, mon_off;
  int           mon_n, hold_viol, fire_cnt, fire_bad;
  bit           seen [256];
  bit           mon_on, en_seen;
  logic         mon_fire;

  // Observes handshakes and lane requests just after the falling edge.
  always @(negedge clock) begin
    #1;
    if (bus.dram_en != 8'h00) en_seen = 1'b1;
    if (bus.out_valid && bus.out_ready) got_q.push_back(bus.out_entry);
    for (int j = 0; j < 8; j++) begin
      mon_fire = bus.dram_en[j] && bus.dram_valid[j];
      if (mon_on) begin
        if (prev_en[j] && !prev_fire[j] && (!bus.dram_en[j] || bus.dram_addr[j] != prev_addr[j]))
          hold_viol++;
        if (prev_fire[j] && bus.dram_en[j] && bus.dram_addr[j] == prev_addr[j])
          hold_viol++;
        if (mon_fire) begin
          mon_off = bus.dram_addr[j] - mon_base;
          fire_cnt++;
          if (mon_off >= 64'(16 * mon_n) || mon_off[2:0] != 3'(j) || seen[mon_off[7:0]]) fire_bad++;
          else seen[mon_off[7:0]] = 1'b1;
        end
      end
      prev_en[j]   = mon_on && bus.dram_en[j];
      prev_fire[j] = mon_on && mon_fire;
      prev_addr[j] = bus.dram_addr[j];
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic start_test(input logic [63:0] b, input int n);
    mon_base  = b;
    mon_n     = n;
    fire_cnt  = 0;
    fire_bad  = 0;
    hold_viol = 0;
    en_seen   = 1'b0;
    foreach (seen[k]) seen[k] = 1'b0;
    got_q.delete();
  endtask

  task automatic pulse_start(input logic [63:0] b, input int n);
    @(negedge clock);
    start       = 1'b1;
    base_addr   = b;
    num_entries = CNT_W'(n);
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic set_latency(input bit rnd, input int slow_lanes_lat);
    lat_rand = rnd;
    for (int j = 0; j < 8; j++) lat_fix[j] = (j >= 5) ? slow_lanes_lat : 0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_entries = '0;
    bus.out_ready = 1'b0; spur = '0; mon_on = 1'b0;
    set_latency(1'b0, 0);
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b, expected 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b, expected 0", done); else passes++;
    checks++; if (bus.dram_en !== 8'h00) $display("[TB] FAIL reset_en: got %h, expected 00", bus.dram_en); else passes++;
    checks++; if (bus.dram_addr !== '0) $display("[TB] FAIL reset_addr: got %h, expected 0", bus.dram_addr); else passes++;
    checks++; if (bus.dram_rdwr !== 1'b0) $display("[TB] FAIL reset_rdwr: got %b, expected 0", bus.dram_rdwr); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid: got %b, expected 0", bus.out_valid); else passes++;
    checks++; if (bus.out_entry !== '0) $display("[TB] FAIL reset_out_entry: got %h, expected 0", bus.out_entry); else passes++;
    reset = 1'b0;
    @(negedge clock);
    mon_on = 1'b1;
  endtask

  task automatic test_single;
    int bad, cyc;
    logic [128:0] got;
    set_latency(1'b0, 0);
    bus.out_ready = 1'b1;
    start_test(64'h1000, 1);
    pulse_start(64'h1000, 1);
    bad = 0;
    for (int j = 0; j < 8; j++) if (bus.dram_en[j] !== 1'b1 || bus.dram_addr[j] !== 64'h1000 + 64'(j)) bad++;
    checks++; if (bad != 0) $display("[TB] FAIL single_lo_addr: %0d lanes wrong, expected 0", bad); else passes++;
    @(negedge clock);
    bad = 0;
    for (int j = 0; j < 8; j++) if (bus.dram_en[j] !== 1'b1 || bus.dram_addr[j] !== 64'h1008 + 64'(j)) bad++;
    checks++; if (bad != 0) $display("[TB] FAIL single_hi_addr: %0d lanes wrong, expected 0", bad); else passes++;
    cyc = 2;
    while (done !== 1'b1 && cyc < 50) begin @(negedge clock); cyc++; end
    checks++; if (done !== 1'b1) $display("[TB] FAIL single_done: got %b, expected 1", done); else passes++;
    checks++; if (cyc != 4) $display("[TB] FAIL single_latency: got %0d cycles, expected 4", cyc); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL single_busy_after: got %b, expected 0", busy); else passes++;
    checks++; if (got_q.size() != 1) $display("[TB] FAIL single_count: got %0d, expected 1", got_q.size()); else passes++;
    got = (got_q.size() > 0) ? got_q[0] : 'x;
    checks++; if (got !== model_entry(64'h1000, 0)) $display("[TB] FAIL single_entry: got %h, expected %h", got, model_entry(64'h1000, 0)); else passes++;
    checks++; if (got !== {1'b1, 128'h0F0E0D0C0B0A09080706050403020100})
      $display("[TB] FAIL single_literal: got %h, expected %h", got, {1'b1, 128'h0F0E0D0C0B0A09080706050403020100}); else passes++;
    @(negedge clock);
    checks++; if (done !== 1'b0) $display("[TB] FAIL single_done_pulse: got %b, expected 0", done); else passes++;
  endtask

  task automatic test_back_to_back;
    int cyc;
    logic [63:0] b;
    logic [128:0] got;
    b = {$urandom, $urandom};
    set_latency(1'b0, 0);
    bus.out_ready = 1'b1;
    start_test(b, 4);
    pulse_start(b, 4);
    cyc = 1;
    while (done !== 1'b1 && cyc < 100) begin @(negedge clock); cyc++; end
    checks++; if (done !== 1'b1) $display("[TB] FAIL b2b_done: got %b, expected 1", done); else passes++;
    checks++; if (cyc != 13) $display("[TB] FAIL b2b_throughput: got %0d cycles, expected 13", cyc); else passes++;
    checks++; if (got_q.size() != 4) $display("[TB] FAIL b2b_count: got %0d, expected 4", got_q.size()); else passes++;
    for (int i = 0; i < 4; i++) begin
      got = (i < got_q.size()) ? got_q[i] : 'x;
      checks++; if (got !== model_entry(b, i)) $display("[TB] FAIL b2b_entry%0d: got %h, expected %h", i, got, model_entry(b, i)); else passes++;
    end
    checks++; if (fire_cnt != 64 || fire_bad != 0) $display("[TB] FAIL b2b_lanes: got %0d fires %0d bad, expected 64 fires 0 bad", fire_cnt, fire_bad); else passes++;
  endtask

  task automatic test_random_latency;
    int cyc;
    logic [63:0] b;
    logic [128:0] got;
    b = {$urandom, $urandom};
    set_latency(1'b1, 0);
    bus.out_ready = 1'b1;
    start_test(b, 3);
    pulse_start(b, 3);
    cyc = 1;
    while (done !== 1'b1 && cyc < 300) begin @(negedge clock); cyc++; end
    checks++; if (done !== 1'b1) $display("[TB] FAIL rand_done: got %b, expected 1", done); else passes++;
    checks++; if (got_q.size() != 3) $display("[TB] FAIL rand_count: got %0d, expected 3", got_q.size()); else passes++;
    for (int i = 0; i < 3; i++) begin
      got = (i < got_q.size()) ? got_q[i] : 'x;
      checks++; if (got !== model_entry(b, i)) $display("[TB] FAIL rand_entry%0d: got %h, expected %h", i, got, model_entry(b, i)); else passes++;
    end
    checks++; if (fire_cnt != 48) $display("[TB] FAIL rand_fire_count: got %0d, expected 48", fire_cnt); else passes++;
    checks++; if (fire_bad != 0) $display("[TB] FAIL rand_fire_addr: got %0d bad, expected 0", fire_bad); else passes++;
    checks++; if (hold_viol != 0) $display("[TB] FAIL rand_lane_hold: got %0d violations, expected 0", hold_viol); else passes++;
  endtask

  task automatic test_backpressure;
    int cyc, stall_bad;
    logic [63:0] b;
    logic [128:0] snap, got;
    b = {$urandom, $urandom};
    set_latency(1'b0, 0);
    bus.out_ready = 1'b0;
    start_test(b, 2);
    pulse_start(b, 2);
    cyc = 1;
    while (bus.out_valid !== 1'b1 && cyc < 50) begin @(negedge clock); cyc++; end
    snap = bus.out_entry;
    checks++; if (snap !== model_entry(b, 0)) $display("[TB] FAIL bp_first_entry: got %h, expected %h", snap, model_entry(b, 0)); else passes++;
    stall_bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      if (bus.out_valid !== 1'b1 || bus.out_entry !== snap || bus.dram_en !== 8'h00) stall_bad++;
    end
    checks++; if (stall_bad != 0) $display("[TB] FAIL bp_stall_stable: got %0d bad cycles, expected 0", stall_bad); else passes++;
    bus.out_ready = 1'b1;
    @(negedge clock);
    checks++; if (bus.dram_en !== 8'hFF || bus.dram_addr[0] !== b + 64'd16)
      $display("[TB] FAIL bp_next_fetch: got en %h addr %h, expected en ff addr %h", bus.dram_en, bus.dram_addr[0], b + 64'd16); else passes++;
    cyc = 0;
    while (done !== 1'b1 && cyc < 50) begin @(negedge clock); cyc++; end
    checks++; if (done !== 1'b1) $display("[TB] FAIL bp_done: got %b, expected 1", done); else passes++;
    checks++; if (got_q.size() != 2) $display("[TB] FAIL bp_count: got %0d, expected 2", got_q.size()); else passes++;
    got = (got_q.size() > 1) ? got_q[1] : 'x;
    checks++; if (got !== model_entry(b, 1)) $display("[TB] FAIL bp_second_entry: got %h, expected %h", got, model_entry(b, 1)); else passes++;
  endtask

  task automatic test_zero_entries;
    start_test(64'h5000, 0);
    pulse_start(64'h5000, 0);
    checks++; if (done !== 1'b1) $display("[TB] FAIL zero_done: got %b, expected 1", done); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL zero_busy: got %b, expected 0", busy); else passes++;
    @(negedge clock);
    checks++; if (done !== 1'b0) $display("[TB] FAIL zero_done_pulse: got %b, expected 0", done); else passes++;
    repeat (3) @(negedge clock);
    checks++; if (en_seen !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL zero_no_fetch: got en_seen %b busy %b, expected 0 0", en_seen, busy); else passes++;
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic [63:0] b, b2;
    logic [128:0] got;
    b = {$urandom, $urandom};
    set_latency(1'b0, 30);
    bus.out_ready = 1'b1;
    start_test(b, 1);
    pulse_start(b, 1);
    cyc = 0;
    while (!(bus.dram_en === 8'hE0 && bus.dram_addr[5] === b + 64'd13) && cyc < 200) begin @(negedge clock); cyc++; end
    checks++; if (bus.dram_addr[5] !== b + 64'd13) $display("[TB] FAIL rst_reach_hi: got %h, expected %h", bus.dram_addr[5], b + 64'd13); else passes++;
    mon_on = 1'b0;
    reset  = 1'b1;
    @(negedge clock);
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL rst_mid_status: got busy %b done %b, expected 0 0", busy, done); else passes++;
    checks++; if (bus.dram_en !== 8'h00) $display("[TB] FAIL rst_mid_en: got %h, expected 00", bus.dram_en); else passes++;
    checks++; if (bus.dram_addr !== '0) $display("[TB] FAIL rst_mid_addr: got %h, expected 0", bus.dram_addr); else passes++;
    checks++; if (bus.out_valid !== 1'b0 || bus.out_entry !== '0) $display("[TB] FAIL rst_mid_out: got %b %h, expected 0 0", bus.out_valid, bus.out_entry); else passes++;
    reset = 1'b0;
    set_latency(1'b0, 0);
    spur    = 8'hFF;
    en_seen = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (en_seen !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL rst_late_valid: got en_seen %b busy %b, expected 0 0", en_seen, busy); else passes++;
    spur = '0;
    @(negedge clock);
    b2 = {$urandom, $urandom};
    start_test(b2, 2);
    mon_on = 1'b1;
    pulse_start(b2, 2);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin @(negedge clock); cyc++; end
    checks++; if (done !== 1'b1) $display("[TB] FAIL rst_refetch_done: got %b, expected 1", done); else passes++;
    checks++; if (got_q.size() != 2) $display("[TB] FAIL rst_refetch_count: got %0d, expected 2", got_q.size()); else passes++;
    for (int i = 0; i < 2; i++) begin
      got = (i < got_q.size()) ? got_q[i] : 'x;
      checks++; if (got !== model_entry(b2, i)) $display("[TB] FAIL rst_refetch_entry%0d: got %h, expected %h", i, got, model_entry(b2, i)); else passes++;
    end
  endtask

  task automatic test_busy_start;
    int cyc;
    logic [63:0] b;
    logic [128:0] got;
    b = 64'hFFFF_FFFF_FFFF_FFF8;
    set_latency(1'b1, 0);
    bus.out_ready = 1'b1;
    start_test(b, 2);
    pulse_start(b, 2);
    repeat (3) @(negedge clock);
    checks++; if (busy !== 1'b1) $display("[TB] FAIL busy_precond: got %b, expected 1", busy); else passes++;
    pulse_start(64'h2000, 5);
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin @(negedge clock); cyc++; end
    checks++; if (done !== 1'b1) $display("[TB] FAIL busy_done: got %b, expected 1", done); else passes++;
    for (int i = 0; i < 2; i++) begin
      got = (i < got_q.size()) ? got_q[i] : 'x;
      checks++; if (got !== model_entry(b, i)) $display("[TB] FAIL wrap_entry%0d: got %h, expected %h", i, got, model_entry(b, i)); else passes++;
    end
    checks++; if (fire_cnt != 32 || fire_bad != 0) $display("[TB] FAIL wrap_lanes: got %0d fires %0d bad, expected 32 fires 0 bad", fire_cnt, fire_bad); else passes++;
    checks++; if (hold_viol != 0) $display("[TB] FAIL wrap_lane_hold: got %0d violations, expected 0", hold_viol); else passes++;
    repeat (5) @(negedge clock);
    checks++; if (busy !== 1'b0 || got_q.size() != 2) $display("[TB] FAIL busy_start_ignored: got busy %b count %0d, expected 0 2", busy, got_q.size()); else passes++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_random_latency;
    test_backpressure;
    test_zero_entries;
    test_reset_mid;
    test_busy_start;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
